i2c_register_responder: RTL and testbench

- I2C target (responder) that answers the same 7-bit-address, register-pointer write protocol that chrontel_serial_bus_driver issues as initiator.
- Holds a local register file that the initiator can write and read back.
- Placed beside the CH7301C path as an on-FPGA stand-in target. Gives loopback verification of the configuration sequence without the external chip, and exposes the written registers to fabric logic.
- SCL and SDA are oversampled in the clk25_2 domain; SDA is driven open-drain only.

---
 rtl/i2c_register_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_register_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_register_responder.sv
// rtl/i2c_register_responder.sv - I2C target with a pointer-addressed register file exposed to fabric logic
// SCL/SDA are synchronized and glitch-filtered in clk25_2; SDA is only ever pulled low.
module i2c_register_responder #(
  parameter logic [6:0] DEVICE_ADDR = 7'h76,
  parameter int         REG_ADDR_W  = 7,
  parameter int         FILTER_LEN  = 3
) (
  input  logic                  clk25_2,
  input  logic                  reset,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic                  busy,
  output logic                  wr_strobe,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  input  logic [REG_ADDR_W-1:0] fab_rd_addr,
  output logic [7:0]            fab_rd_data
);

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_ADDR    = 4'd1;
  localparam logic [3:0] ST_ACK     = 4'd2;
  localparam logic [3:0] ST_PTR     = 4'd3;
  localparam logic [3:0] ST_WDATA   = 4'd4;
  localparam logic [3:0] ST_RD_LOAD = 4'd5;
  localparam logic [3:0] ST_RD_DATA = 4'd6;
  localparam logic [3:0] ST_RD_ACK  = 4'd7;
  localparam logic [3:0] ST_IGNORE  = 4'd8;
  localparam int         DEPTH      = 1 << REG_ADDR_W;

  logic [1:0]            scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [FILTER_LEN-1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic                  scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic                  scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  logic [3:0]            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic                  rw_q, rw_d;
  logic                  ack_after_addr_q, ack_after_addr_d;
  logic [REG_ADDR_W-1:0] ptr_q, ptr_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            fab_rd_data_q, fab_rd_data_d;
  logic                  reg_we;
  logic [7:0]            regs_q [DEPTH];

  logic scl_rise, scl_fall, start_cond, stop_cond, last_bit;
  logic [7:0] shift_in;

  // A new level is accepted only once FILTER_LEN synchronized samples agree.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_in};
    sda_sync_d = {sda_sync_q[0], sda_in};
    scl_hist_d = {scl_hist_q[FILTER_LEN-2:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[FILTER_LEN-2:0], sda_sync_q[1]};
    scl_f_d    = scl_f_q;
    sda_f_d    = sda_f_q;
    if (&scl_hist_q)       scl_f_d = 1'b1;
    else if (~|scl_hist_q) scl_f_d = 1'b0;
    if (&sda_hist_q)       sda_f_d = 1'b1;
    else if (~|sda_hist_q) sda_f_d = 1'b0;
    scl_prev_d = scl_f_q;
    sda_prev_d = sda_f_q;
  end

  assign scl_rise   = scl_f_q & ~scl_prev_q;
  assign scl_fall   = ~scl_f_q & scl_prev_q;
  assign start_cond = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
  assign stop_cond  = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
  assign shift_in   = {shift_q[6:0], sda_f_q};
  assign last_bit   = (bit_cnt_q == 4'd7);

  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    shift_d          = shift_q;
    rw_d             = rw_q;
    ack_after_addr_d = ack_after_addr_q;
    ptr_d            = ptr_q;
    sda_oe_d         = sda_oe_q;
    busy_d           = busy_q;
    wr_strobe_d      = 1'b0;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    reg_we           = 1'b0;
    fab_rd_data_d    = regs_q[fab_rd_addr];

    case (state_q)
      ST_ADDR: if (scl_rise) begin
        shift_d   = shift_in;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (last_bit) begin
          rw_d             = sda_f_q;
          ack_after_addr_d = 1'b1;
          state_d          = (shift_in[7:1] == DEVICE_ADDR) ? ST_ACK : ST_IGNORE;
        end
      end
      ST_PTR: if (scl_rise) begin
        shift_d   = shift_in;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (last_bit) begin
          ptr_d            = shift_in[REG_ADDR_W-1:0];
          ack_after_addr_d = 1'b0;
          state_d          = ST_ACK;
        end
      end
      ST_WDATA: if (scl_rise) begin
        shift_d   = shift_in;
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (last_bit) begin
          reg_we           = 1'b1;
          wr_strobe_d      = 1'b1;
          wr_addr_d        = ptr_q;
          wr_data_d        = shift_in;
          ptr_d            = ptr_q + 1'b1;
          ack_after_addr_d = 1'b0;
          state_d          = ST_ACK;
        end
      end
      // A read ACK hands over at the first fall so the next fall can carry data bit 7.
      ST_ACK: if (scl_fall) begin
        if (!sda_oe_q) begin
          sda_oe_d = 1'b1;
          if (ack_after_addr_q && rw_q) state_d = ST_RD_LOAD;
        end else begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = ack_after_addr_q ? ST_PTR : ST_WDATA;
        end
      end
      ST_RD_LOAD: begin
        shift_d   = regs_q[ptr_q];
        ptr_d     = ptr_q + 1'b1;
        bit_cnt_d = 4'd0;
        state_d   = ST_RD_DATA;
      end
      ST_RD_DATA: if (scl_fall) begin
        if (bit_cnt_q == 4'd8) begin
          sda_oe_d = 1'b0;
          state_d  = ST_RD_ACK;
        end else begin
          sda_oe_d  = ~shift_q[7];
          shift_d   = {shift_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_RD_ACK: if (scl_rise) state_d = sda_f_q ? ST_IGNORE : ST_RD_LOAD;
      default: ;
    endcase

    if (start_cond || stop_cond) begin
      sda_oe_d    = 1'b0;
      bit_cnt_d   = 4'd0;
      ptr_d       = ptr_q;
      reg_we      = 1'b0;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      busy_d      = start_cond;
      state_d     = start_cond ? ST_ADDR : ST_IDLE;
    end
  end

  always_ff @(posedge clk25_2 or posedge reset) begin
    if (reset) begin
      scl_sync_q       <= '1;
      sda_sync_q       <= '1;
      scl_hist_q       <= '1;
      sda_hist_q       <= '1;
      scl_f_q          <= 1'b1;
      sda_f_q          <= 1'b1;
      scl_prev_q       <= 1'b1;
      sda_prev_q       <= 1'b1;
      state_q          <= ST_IDLE;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      rw_q             <= 1'b0;
      ack_after_addr_q <= 1'b0;
      ptr_q            <= '0;
      sda_oe_q         <= 1'b0;
      busy_q           <= 1'b0;
      wr_strobe_q      <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      fab_rd_data_q    <= '0;
    end else begin
      scl_sync_q       <= scl_sync_d;
      sda_sync_q       <= sda_sync_d;
      scl_hist_q       <= scl_hist_d;
      sda_hist_q       <= sda_hist_d;
      scl_f_q          <= scl_f_d;
      sda_f_q          <= sda_f_d;
      scl_prev_q       <= scl_prev_d;
      sda_prev_q       <= sda_prev_d;
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      rw_q             <= rw_d;
      ack_after_addr_q <= ack_after_addr_d;
      ptr_q            <= ptr_d;
      sda_oe_q         <= sda_oe_d;
      busy_q           <= busy_d;
      wr_strobe_q      <= wr_strobe_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      fab_rd_data_q    <= fab_rd_data_d;
    end
  end

  always_ff @(posedge clk25_2 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else if (reg_we) begin
      regs_q[ptr_q] <= shift_in;
    end
  end

  // Gate with reset so the bus is freed in the very cycle reset rises.
  assign sda_oe      = sda_oe_q & ~reset;
  assign busy        = busy_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign fab_rd_data = fab_rd_data_q;

endmodule

// File: tb/tb_i2c_register_responder.sv
// tb/tb_i2c_register_responder.sv - bench for i2c_register_responder
// Bit-banged I2C initiator plus a register-file model of what the target should hold.
module tb_i2c_register_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       glitch = 1'b0;
  logic [6:0] fab_rd_addr = 7'h00;
  logic       sda_oe, busy, wr_strobe;
  logic [6:0] wr_addr;
  logic [7:0] wr_data, fab_rd_data;
  logic       sda_line;

  assign sda_line = sda_m & ~glitch & ~sda_oe;

  always #5 clk = ~clk;

  i2c_register_responder dut (
    .clk25_2    (clk),
    .reset      (rst),
    .scl_in     (scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .fab_rd_addr(fab_rd_addr),
    .fab_rd_data(fab_rd_data)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mdl_regs [128];
  int         mdl_ptr = 0;

  logic [14:0] strobe_log [256];
  logic [7:0]  strobe_fab [256];
  int          strobe_cnt = 0;
  int          oe_cnt = 0;

  always @(negedge clk) begin
    if (wr_strobe) begin
      strobe_log[strobe_cnt % 256] = {wr_addr, wr_data};
      strobe_fab[strobe_cnt % 256] = fab_rd_data;
      strobe_cnt = strobe_cnt + 1;
    end
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    cyc(10); sda_m = 1'b0; cyc(20); scl = 1'b0;
  endtask

  task automatic i2c_rstart();
    cyc(10); sda_m = 1'b1; cyc(10); scl = 1'b1; cyc(20); sda_m = 1'b0; cyc(20); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    cyc(10); sda_m = 1'b0; cyc(10); scl = 1'b1; cyc(20); sda_m = 1'b1; cyc(20);
  endtask

  task automatic send_bit(input logic b, input bit glitch_hi);
    cyc(10); sda_m = b; cyc(10); scl = 1'b1; cyc(10);
    if (glitch_hi) begin glitch = 1'b1; cyc(1); glitch = 1'b0; end
    cyc(10); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    cyc(10); sda_m = 1'b1; cyc(10); scl = 1'b1; cyc(10); b = sda_line; cyc(10); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit glitch_first);
    for (int i = 7; i >= 0; i--) send_bit(v[i], glitch_first && (i == 7));
  endtask

  task automatic recv_byte(output logic [7:0] v);
    logic b;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin recv_bit(b); v = {v[6:0], b}; end
  endtask

  task automatic fab_read(input logic [6:0] a, output logic [7:0] v);
    fab_rd_addr = a; cyc(2); v = fab_rd_data;
  endtask

  // Write transaction: address byte, pointer byte, n data bytes, STOP.
  task automatic write_txn(input string tag, input logic [7:0] ab, input logic [7:0] p,
                           input int n, input logic [7:0] d [8], input bit glitch_first);
    logic        a;
    bit          match;
    int          s0, oe0;
    logic [7:0]  old;
    logic [14:0] exp_log [8];
    match = (ab[7:1] == 7'h76) && (ab[0] == 1'b0);
    s0 = strobe_cnt;
    oe0 = oe_cnt;
    fab_rd_addr = p[6:0];
    old = mdl_regs[p[6:0]];
    i2c_start();
    check({tag, "_busy_start"}, 32'(busy), 1);
    send_byte(ab, glitch_first); recv_bit(a);
    check({tag, "_addr_ack"}, 32'(a), match ? 0 : 1);
    send_byte(p, 1'b0); recv_bit(a);
    check({tag, "_ptr_ack"}, 32'(a), match ? 0 : 1);
    if (match) mdl_ptr = p % 128;
    for (int k = 0; k < n; k++) begin
      send_byte(d[k], 1'b0); recv_bit(a);
      check({tag, "_data_ack"}, 32'(a), match ? 0 : 1);
      if (match) begin
        exp_log[k] = {7'(mdl_ptr), d[k]};
        mdl_regs[mdl_ptr] = d[k];
        mdl_ptr = (mdl_ptr + 1) % 128;
      end
    end
    i2c_stop();
    check({tag, "_busy_stop"}, 32'(busy), 0);
    check({tag, "_strobe_count"}, 32'(strobe_cnt - s0), match ? n : 0);
    if (match) begin
      for (int k = 0; k < n; k++)
        check({tag, "_strobe"}, 32'(strobe_log[(s0 + k) % 256]), 32'(exp_log[k]));
      check({tag, "_collide_old"}, 32'(strobe_fab[s0 % 256]), 32'(old));
    end else begin
      check({tag, "_no_drive"}, 32'(oe_cnt - oe0), 0);
    end
  endtask

  // Read transaction, optionally setting the pointer first via a repeated START.
  task automatic read_txn(input string tag, input bit set_ptr, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] v;
    int         oe0;
    i2c_start();
    if (set_ptr) begin
      send_byte(8'hEC, 1'b0); recv_bit(a); check({tag, "_waddr_ack"}, 32'(a), 0);
      send_byte(p, 1'b0); recv_bit(a); check({tag, "_ptr_ack"}, 32'(a), 0);
      mdl_ptr = p % 128;
      i2c_rstart();
      check({tag, "_busy_rstart"}, 32'(busy), 1);
    end
    send_byte(8'hED, 1'b0); recv_bit(a); check({tag, "_raddr_ack"}, 32'(a), 0);
    for (int k = 0; k < n; k++) begin
      recv_byte(v);
      check({tag, "_rdata"}, 32'(v), 32'(mdl_regs[mdl_ptr]));
      mdl_ptr = (mdl_ptr + 1) % 128;
      send_bit(k == n - 1, 1'b0);
    end
    oe0 = oe_cnt;
    i2c_stop();
    check({tag, "_no_drive_after_nack"}, 32'(oe_cnt - oe0), 0);
    check({tag, "_busy_stop"}, 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] dbuf [8];
    logic [7:0] v;
    logic [7:0] p;
    logic       a;
    int         n;
    for (int i = 0; i < 128; i++) mdl_regs[i] = 8'h00;
    for (int i = 0; i < 8; i++) dbuf[i] = 8'h00;

    cyc(3);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_wr_strobe", 32'(wr_strobe), 0);
    rst = 1'b0;
    cyc(3);
    for (int i = 0; i < 128; i++) begin
      fab_read(7'(i), v);
      check("rst_fab_rd", 32'(v), 0);
    end

    dbuf[0] = 8'hC0;
    write_txn("wr_49", 8'hEC, 8'h49, 1, dbuf, 1'b0);
    fab_read(7'h49, v); check("fab_49", 32'(v), 32'(mdl_regs[7'h49]));

    dbuf[0] = 8'h11; dbuf[1] = 8'h22;
    write_txn("wr_wrap", 8'hEC, 8'h7F, 2, dbuf, 1'b0);
    fab_read(7'h7F, v); check("fab_7f", 32'(v), 32'h11);
    fab_read(7'h00, v); check("fab_00", 32'(v), 32'h22);

    dbuf[0] = 8'h3C; dbuf[1] = 8'hA7;
    write_txn("wr_4a", 8'hEC, 8'h4A, 2, dbuf, 1'b0);
    read_txn("rd_49", 1'b1, 8'h49, 2);
    read_txn("rd_ptr_4b", 1'b0, 8'h00, 1);

    dbuf[0] = 8'h55;
    write_txn("wr_other_addr", 8'hEE, 8'h49, 1, dbuf, 1'b0);
    fab_read(7'h49, v); check("fab_49_unchanged", 32'(v), 32'hC0);

    cyc(5); glitch = 1'b1; cyc(1); glitch = 1'b0; cyc(15);
    check("glitch_idle_busy", 32'(busy), 0);
    dbuf[0] = 8'h9E;
    write_txn("wr_glitch", 8'hEC, 8'h20, 1, dbuf, 1'b1);

    i2c_start();
    send_byte(8'hEC, 1'b0); recv_bit(a); check("rstmid_addr_ack", 32'(a), 0);
    send_byte(8'h10, 1'b0); recv_bit(a); check("rstmid_ptr_ack", 32'(a), 0);
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 60 && !sda_oe; i++) cyc(1);
    check("rstmid_ack_drive", 32'(sda_oe), 1);
    rst = 1'b1;
    #1;
    check("rstmid_release", 32'(sda_oe), 0);
    for (int i = 0; i < 128; i++) mdl_regs[i] = 8'h00;
    mdl_ptr = 0;
    cyc(3); scl = 1'b1; sda_m = 1'b1; cyc(5);
    rst = 1'b0;
    cyc(10);
    check("rstmid_busy", 32'(busy), 0);
    fab_read(7'h10, v); check("rstmid_cleared", 32'(v), 0);
    dbuf[0] = 8'h5A;
    write_txn("wr_after_rst", 8'hEC, 8'h10, 1, dbuf, 1'b0);
    fab_read(7'h10, v); check("fab_after_rst", 32'(v), 32'h5A);

    for (int it = 0; it < 4; it++) begin
      p = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 4);
      for (int k = 0; k < 8; k++) dbuf[k] = 8'($urandom);
      write_txn("rnd_wr", 8'hEC, p, n, dbuf, 1'b0);
      read_txn("rnd_rd", 1'b1, 8'(p[6:0] + 7'($urandom_range(0, 3))), $urandom_range(1, 4));
      fab_read(p[6:0], v); check("rnd_fab", 32'(v), 32'(mdl_regs[p[6:0]]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
